// File: rtl/neighbor_builder.sv
// neighbor_builder: builds the per-vertex adjacency table in RAM_NBR from the
// face list in RAM_OBJ, ahead of the averaging pass.
// Ports: clk, rst (async, active high), start/busy handshake, vertex_count,
//   face_count, RAM_OBJ_* (read-only master), RAM_NBR_* (read/write master),
//   overflow (sticky: a neighbor was dropped because its block was full).
// Option macro NBR_INDEX_CHECK_EN: skip faces holding an index of 0 or above
//   vertex_count and report them on the sticky bad_face output.
// State advances on the falling edge; the RAMs sample on the rising edge, so
// read data for an address driven at one negedge is valid at the next one.
module neighbor_builder #(
    parameter int MAX_NEIGHBOR_COUNT = 10,
    parameter int ADDR_WIDTH         = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           vertex_count,
    input  logic [31:0]           face_count,
    input  logic [31:0]           RAM_OBJ_Do,
    input  logic [31:0]           RAM_NBR_Do,
    output logic                  RAM_OBJ_EN,
    output logic [3:0]            RAM_OBJ_WE,
    output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
    output logic [31:0]           RAM_OBJ_Di,
    output logic                  RAM_NBR_EN,
    output logic [3:0]            RAM_NBR_WE,
    output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
    output logic [31:0]           RAM_NBR_Di,
    output logic                  busy,
`ifdef NBR_INDEX_CHECK_EN
    output logic                  bad_face,
`endif
    output logic                  overflow
);

    localparam logic [31:0] LAST = 32'(MAX_NEIGHBOR_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] MAX_A = ADDR_WIDTH'(MAX_NEIGHBOR_COUNT);
    localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

    typedef enum logic [3:0] {
        IDLE, CLEAR, FETCH, PAIR, RD_CNT, SCAN, APPEND, NEXT, DONE
    } state_t;

    state_t                  state;
    logic [31:0]             vi, face, slot, cnt;
    logic [31:0]             a, b, c;
    logic [1:0]              k;
    logic [2:0]              p;
    logic                    ph;
    logic [ADDR_WIDTH-1:0]   base;
    logic [31:0]             src, dst;
    logic [ADDR_WIDTH-1:0]   blk, obj0;

    assign RAM_OBJ_WE = 4'b0;
    assign RAM_OBJ_Di = 32'b0;

    // Pair order within a face: (a,b),(a,c),(b,a),(b,c),(c,a),(c,b).
    always_comb begin
        src = a;
        dst = b;
        case (p)
            3'd1:    begin src = a; dst = c; end
            3'd2:    begin src = b; dst = a; end
            3'd3:    begin src = b; dst = c; end
            3'd4:    begin src = c; dst = a; end
            3'd5:    begin src = c; dst = b; end
            default: begin src = a; dst = b; end
        endcase
    end

    assign blk  = (src[ADDR_WIDTH-1:0] - ONE_A) * MAX_A;
    assign obj0 = vertex_count[ADDR_WIDTH-1:0] * ADDR_WIDTH'(3) + ONE_A;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            overflow   <= 1'b0;
`ifdef NBR_INDEX_CHECK_EN
            bad_face   <= 1'b0;
`endif
            RAM_OBJ_EN <= 1'b0;
            RAM_OBJ_A  <= '0;
            RAM_NBR_EN <= 1'b0;
            RAM_NBR_WE <= 4'b0;
            RAM_NBR_A  <= '0;
            RAM_NBR_Di <= 32'b0;
            vi         <= 32'b0;
            face       <= 32'b0;
            slot       <= 32'b0;
            cnt        <= 32'b0;
            a          <= 32'b0;
            b          <= 32'b0;
            c          <= 32'b0;
            k          <= 2'b0;
            p          <= 3'b0;
            ph         <= 1'b0;
            base       <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    overflow   <= 1'b0;
`ifdef NBR_INDEX_CHECK_EN
                    bad_face   <= 1'b0;
`endif
                    busy       <= 1'b1;
                    RAM_OBJ_EN <= 1'b1;
                    RAM_NBR_EN <= 1'b1;
                    RAM_NBR_A  <= '0;
                    RAM_NBR_Di <= 32'b0;
                    RAM_NBR_WE <= (vertex_count != 0) ? 4'hf : 4'h0;
                    vi         <= 32'b0;
                    face       <= 32'b0;
                    state      <= CLEAR;
                end
                // One count word zeroed per cycle; the write is already on the bus.
                CLEAR: begin
                    if (vertex_count == 0 || vi + 32'd1 == vertex_count) begin
                        RAM_NBR_WE <= 4'h0;
                        RAM_OBJ_A  <= obj0;
                        k          <= 2'd0;
                        if (vertex_count == 0 || face_count == 0) begin
                            RAM_OBJ_EN <= 1'b0;
                            RAM_NBR_EN <= 1'b0;
                            state      <= DONE;
                        end else begin
                            state <= FETCH;
                        end
                    end else begin
                        vi        <= vi + 32'd1;
                        RAM_NBR_A <= RAM_NBR_A + MAX_A;
                    end
                end
                FETCH: begin
                    case (k)
                        2'd0: begin
                            a         <= RAM_OBJ_Do;
                            RAM_OBJ_A <= RAM_OBJ_A + ONE_A;
                            k         <= 2'd1;
                        end
                        2'd1: begin
                            b         <= RAM_OBJ_Do;
                            RAM_OBJ_A <= RAM_OBJ_A + ONE_A;
                            k         <= 2'd2;
                        end
                        default: begin
                            c     <= RAM_OBJ_Do;
                            p     <= 3'd0;
                            state <= PAIR;
`ifdef NBR_INDEX_CHECK_EN
                            if (a == 0 || a > vertex_count ||
                                b == 0 || b > vertex_count ||
                                RAM_OBJ_Do == 0 || RAM_OBJ_Do > vertex_count) begin
                                bad_face <= 1'b1;
                                p        <= 3'd5;
                                state    <= NEXT;
                            end
`endif
                        end
                    endcase
                end
                PAIR: begin
                    if (src == dst) begin
                        state <= NEXT;
                    end else begin
                        base      <= blk;
                        RAM_NBR_A <= blk;
                        state     <= RD_CNT;
                    end
                end
                RD_CNT: begin
                    cnt       <= RAM_NBR_Do;
                    slot      <= 32'd1;
                    RAM_NBR_A <= base + ONE_A;
                    state     <= SCAN;
                end
                // With cnt==0 the slot-1 data is stale and must be ignored.
                SCAN: begin
                    if (cnt == 0 ||
                        (RAM_NBR_Do != dst && slot == cnt)) begin
                        if (cnt < LAST) begin
                            RAM_NBR_A  <= base + cnt[ADDR_WIDTH-1:0] + ONE_A;
                            RAM_NBR_Di <= dst;
                            RAM_NBR_WE <= 4'hf;
                            ph         <= 1'b0;
                            state      <= APPEND;
                        end else begin
                            overflow <= 1'b1;
                            state    <= NEXT;
                        end
                    end else if (RAM_NBR_Do == dst) begin
                        state <= NEXT;
                    end else begin
                        slot      <= slot + 32'd1;
                        RAM_NBR_A <= RAM_NBR_A + ONE_A;
                    end
                end
                // Neighbor slot first, then the bumped count.
                APPEND: begin
                    if (!ph) begin
                        RAM_NBR_A  <= base;
                        RAM_NBR_Di <= cnt + 32'd1;
                        ph         <= 1'b1;
                    end else begin
                        RAM_NBR_WE <= 4'h0;
                        state      <= NEXT;
                    end
                end
                NEXT: begin
                    if (p == 3'd5) begin
                        if (face + 32'd1 == face_count) begin
                            RAM_OBJ_EN <= 1'b0;
                            RAM_NBR_EN <= 1'b0;
                            state      <= DONE;
                        end else begin
                            face      <= face + 32'd1;
                            RAM_OBJ_A <= RAM_OBJ_A + ONE_A;
                            k         <= 2'd0;
                            state     <= FETCH;
                        end
                    end else begin
                        p     <= p + 3'd1;
                        state <= PAIR;
                    end
                end
                DONE: begin
                    RAM_NBR_WE <= 4'h0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
